// File: rtl/data_mem_responder.sv
// Byte-wide single-port synchronous RAM behind a req/ack handshake.
// Serves byte writes and 5-byte reads (little-endian word Do plus trailing byte Dob).
module data_mem_responder #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [7:0]  din,
  output logic        busy,
  output logic        ack,
  output logic [31:0] Do,
  output logic [7:0]  Dob
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_ACK   = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_LAST  = 3'd3,
    S_RD_ACK   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_k;
  logic [2:0]          w_k_nxt;
  logic [ADDR_W-1:0]   r_base;
  logic [7:0]          r_mem [0:DEPTH-1];
  logic [7:0]          r_rdata;
  logic [31:0]         r_shadow;
  logic                r_busy;
  logic                r_ack;
  logic [31:0]         r_do;
  logic [7:0]          r_dob;

  logic                w_accept;
  logic                w_wr_en;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic                w_ack_nxt;
  logic                w_load_out;
  logic                w_unused_addr;

  assign w_unused_addr = ^addr[31:ADDR_W];
  assign w_accept      = (r_state == S_IDLE) && req && !r_busy && !rst;
  assign w_wr_en       = w_accept && we;

  // Byte 0 is issued straight off the input address at the accept edge.
  always_comb begin
    w_ram_addr = addr[ADDR_W-1:0];
    if (r_state == S_IDLE) begin
      w_ram_addr = addr[ADDR_W-1:0];
    end else begin
      w_ram_addr = r_base + {{(ADDR_W-3){1'b0}}, r_k};
    end
  end

  // Next-state, byte counter and output strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_ack_nxt   = 1'b0;
    w_load_out  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = we ? S_WR_ACK : S_RD_ISSUE;
          w_k_nxt     = 3'd1;
          w_ack_nxt   = we;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WR_ACK:  w_state_nxt = S_IDLE;
      S_RD_ISSUE: begin
        if (r_k == 3'd4) begin
          w_state_nxt = S_RD_LAST;
        end else begin
          w_k_nxt = r_k + 3'd1;
        end
      end
      S_RD_LAST: begin
        w_state_nxt = S_RD_ACK;
        w_ack_nxt   = 1'b1;
        w_load_out  = 1'b1;
      end
      S_RD_ACK:  w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // State register, byte counter and latched base address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= 3'd0;
      r_base  <= {ADDR_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      if (w_accept) begin
        r_base <= addr[ADDR_W-1:0];
      end
    end
  end

  // RAM array: one write or one read per cycle, read data one cycle later.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[addr[ADDR_W-1:0]] <= din;
    end
    r_rdata <= r_mem[w_ram_addr];
  end

  // Shadow word: bytes shift in from the top so byte 0 ends up in [7:0].
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= 32'd0;
    end else if (r_state == S_RD_ISSUE) begin
      r_shadow <= {r_rdata, r_shadow[31:8]};
    end
  end

  // Registered handshake and read outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_ack  <= 1'b0;
      r_do   <= 32'd0;
      r_dob  <= 8'd0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_ack  <= w_ack_nxt;
      if (w_load_out) begin
        r_do  <= r_shadow;
        r_dob <= r_rdata;
      end
    end
  end

  assign busy = r_busy;
  assign ack  = r_ack;
  assign Do   = r_do;
  assign Dob  = r_dob;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (ADDR_W = 10).
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [7:0]  din;
  logic        busy;
  logic        ack;
  logic [31:0] w_do;
  logic [7:0]  w_dob;

  int n_tests;
  int n_fail;

  data_mem_responder #(.ADDR_W(10)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .we   (we),
    .addr (addr),
    .din  (din),
    .busy (busy),
    .ack  (ack),
    .Do   (w_do),
    .Dob  (w_dob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write with ack at n+1 and busy released at n+2; returns in cycle n+2.
  task automatic do_write(input logic [31:0] a, input logic [7:0] d);
    req = 1'b1; we = 1'b1; addr = a; din = d;
    tick();
    req = 1'b0; we = 1'b0;
    check("wr_ack", {31'd0, ack}, 32'd1);
    check("wr_busy", {31'd0, busy}, 32'd1);
    tick();
    check("wr_ack_low", {31'd0, ack}, 32'd0);
    check("wr_idle", {31'd0, busy}, 32'd0);
  endtask

  // Read expecting ack exactly at n+6; returns in cycle n+7.
  task automatic do_read(input string tag, input logic [31:0] a,
                         input logic [31:0] exp_do, input logic [7:0] exp_dob,
                         input logic [31:0] do_mask);
    int cyc;
    req = 1'b1; we = 1'b0; addr = a; din = 8'h00;
    tick();
    req = 1'b0;
    cyc = 1;
    while (ack !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_lat"}, cyc, 32'd6);
    check({tag, "_do"}, w_do & do_mask, exp_do & do_mask);
    if (do_mask == 32'hFFFF_FFFF) begin
      check({tag, "_dob"}, {24'd0, w_dob}, {24'd0, exp_dob});
    end else begin
      check({tag, "_busy_ack"}, {31'd0, busy}, 32'd1);
    end
    tick();
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] wr_a [5];
    logic [7:0]  wr_d [5];
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; din = 8'd0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_do", w_do, 32'd0);
    check("rst_dob", {24'd0, w_dob}, 32'd0);

    // Fill
    for (int i = 0; i < 5; i++) do_write(32'h20 + i, 8'h11 * (i + 1));
    do_read("fill", 32'h20, 32'h4433_2211, 8'h55, 32'hFFFF_FFFF);

    // Wrap
    wr_a = '{32'h3FE, 32'h3FF, 32'h000, 32'h001, 32'h002};
    wr_d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    for (int i = 0; i < 5; i++) do_write(wr_a[i], wr_d[i]);
    do_read("wrap", 32'h3FE, 32'hDDCC_BBAA, 8'hEE, 32'hFFFF_FFFF);

    // Alias: upper address bits ignored
    do_write(32'h400, 8'h5A);
    do_read("alias", 32'h000, 32'h0000_005A, 8'h00, 32'h0000_00FF);

    // Busy ignore: a write request during a read must be dropped
    req = 1'b1; we = 1'b0; addr = 32'h20;
    tick();                           // n+1
    req = 1'b0;
    tick();                           // n+2
    req = 1'b1; we = 1'b1; addr = 32'h21; din = 8'hFF;
    tick();                           // n+3
    req = 1'b0; we = 1'b0;
    tick(); tick(); tick();           // n+6
    check("bi_ack", {31'd0, ack}, 32'd1);
    check("bi_do", w_do, 32'h4433_2211);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bi_no_extra_ack", {31'd0, ack}, 32'd0);
    end
    do_read("bi_reread", 32'h20, 32'h4433_2211, 8'h55, 32'hFFFF_FFFF);

    // Reset mid-read
    req = 1'b1; we = 1'b0; addr = 32'h20;
    tick();                           // n+1
    req = 1'b0;
    check("mr_no_ack1", {31'd0, ack}, 32'd0);
    tick();                           // n+2
    check("mr_no_ack2", {31'd0, ack}, 32'd0);
    tick();                           // n+3
    rst = 1'b1;
    tick();                           // n+4
    rst = 1'b0;
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_ack", {31'd0, ack}, 32'd0);
    check("mr_do", w_do, 32'd0);
    check("mr_dob", {24'd0, w_dob}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mr_quiet", {31'd0, ack}, 32'd0);
    end
    do_read("mr_fresh", 32'h20, 32'h4433_2211, 8'h55, 32'hFFFF_FFFF);

    // Back-to-back: read accepted right at n+2 after the write
    do_write(32'h23, 8'h99);
    do_read("b2b", 32'h20, 32'h9933_2211, 8'h55, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
